// File: rtl/sdram_port_arbiter.sv
// Sequenced arbiter sharing SDRAM controller port 0 between the loader write
// stream (buffered in a small FIFO) and the video burst-read stream.
module sdram_port_arbiter #(
    parameter int FIFO_DEPTH      = 4,
    parameter int WR_HOLD_CYCLES  = 8,
    parameter int RD_DRAIN_CYCLES = 4,
    parameter int MAX_WR_RUN      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_req,
    input  logic [24:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    output logic        wr_overflow,
    input  logic        rd_req,
    input  logic [24:0] rd_addr,
    input  logic        rd_end_burst,
    output logic        rd_ack,
    output logic        rd_data_available,
    output logic [24:0] p0_addr,
    output logic [15:0] p0_data,
    output logic        p0_wr_req,
    output logic        p0_rd_req,
    output logic        p0_end_burst_req,
    input  logic        p0_data_available,
    output logic        busy
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int HOLD_MAX = (WR_HOLD_CYCLES > RD_DRAIN_CYCLES) ? WR_HOLD_CYCLES : RD_DRAIN_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int RUN_W    = $clog2(MAX_WR_RUN + 2);

    localparam logic [PTR_W:0]    DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [HOLD_W-1:0] WR_LOAD    = HOLD_W'(WR_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DRAIN_LOAD = HOLD_W'(RD_DRAIN_CYCLES - 1);
    localparam logic [RUN_W-1:0]  RUN_LIMIT  = RUN_W'(MAX_WR_RUN);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

    state_t            state, state_n;
    logic [40:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic [HOLD_W-1:0] hold, hold_n;
    logic [RUN_W-1:0]  run;
    logic              rd_pending;
    logic [24:0]       rd_addr_q;
    logic [24:0]       cur_addr;
    logic [15:0]       cur_data;
    logic              full, empty, push, pop;
    logic              issue_wr, issue_rd;
    logic [24:0]       head_addr;
    logic [15:0]       head_data;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    // Full is the registered flag, so a push coinciding with a pop on a full FIFO is dropped.
    assign push      = wr_req && !full;
    assign {head_addr, head_data} = mem[rd_ptr];

    assign wr_ready          = !full;
    assign rd_data_available = (state == S_READ) && p0_data_available;
    assign busy              = (state != S_IDLE) || !empty;

    // NOTE: storage array has no reset; only pointers and count need a known state.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {wr_addr, wr_data};
    end

    // NOTE: every output and next-state value gets a default first, so no latches are inferred.
    always_comb begin
        state_n          = state;
        hold_n           = hold;
        pop              = 1'b0;
        issue_wr         = 1'b0;
        issue_rd         = 1'b0;
        p0_wr_req        = 1'b0;
        p0_rd_req        = 1'b0;
        p0_end_burst_req = 1'b0;
        rd_ack           = 1'b0;
        p0_addr          = '0;
        p0_data          = '0;
        case (state)
            S_IDLE: begin
                if (!empty && (!rd_pending || run < RUN_LIMIT)) begin
                    pop       = 1'b1;
                    issue_wr  = 1'b1;
                    p0_wr_req = 1'b1;
                    p0_addr   = head_addr;
                    p0_data   = head_data;
                    hold_n    = WR_LOAD;
                    state_n   = S_WRITE;
                end else if (rd_pending) begin
                    issue_rd  = 1'b1;
                    p0_rd_req = 1'b1;
                    rd_ack    = 1'b1;
                    p0_addr   = rd_addr_q;
                    state_n   = S_READ;
                end
            end
            S_WRITE: begin
                p0_addr = cur_addr;
                p0_data = cur_data;
                if (hold == '0) state_n = S_IDLE;
                else            hold_n  = hold - 1'b1;
            end
            S_READ: begin
                p0_addr = cur_addr;
                if (rd_end_burst) begin
                    p0_end_burst_req = 1'b1;
                    hold_n           = DRAIN_LOAD;
                    state_n          = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (hold == '0) state_n = S_IDLE;
                else            hold_n  = hold - 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            hold        <= '0;
            run         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wr_overflow <= 1'b0;
            rd_pending  <= 1'b0;
            rd_addr_q   <= '0;
            cur_addr    <= '0;
            cur_data    <= '0;
        end else begin
            state <= state_n;
            hold  <= hold_n;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_req && full) wr_overflow <= 1'b1;

            // First request wins; later ones are ignored until the burst has drained.
            if (issue_rd) begin
                rd_pending <= 1'b0;
            end else if (rd_req && !rd_pending && state != S_READ && state != S_DRAIN) begin
                rd_pending <= 1'b1;
                rd_addr_q  <= rd_addr;
            end

            if (!rd_pending || issue_rd) run <= '0;
            else if (issue_wr)           run <= run + 1'b1;

            if (issue_wr) begin
                cur_addr <= head_addr;
                cur_data <= head_data;
            end else if (issue_rd) begin
                cur_addr <= rd_addr_q;
                cur_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed stimulus pushes expected
// port-0 events; a negedge monitor pops and compares them as they appear.
module tb_sdram_port_arbiter;

    localparam logic [1:0] K_WR = 2'd1;
    localparam logic [1:0] K_RD = 2'd2;
    localparam logic [1:0] K_EB = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [24:0] addr;
        logic [15:0] data;
        int          gap;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_req = 1'b0;
    logic [24:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ready, wr_overflow;
    logic        rd_req = 1'b0;
    logic [24:0] rd_addr = '0;
    logic        rd_end_burst = 1'b0;
    logic        rd_ack, rd_data_available;
    logic [24:0] p0_addr;
    logic [15:0] p0_data;
    logic        p0_wr_req, p0_rd_req, p0_end_burst_req;
    logic        p0_data_available = 1'b0;
    logic        busy;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last_cyc = 0;
    ev_t exp_q[$];

    sdram_port_arbiter #(
        .FIFO_DEPTH(4), .WR_HOLD_CYCLES(8), .RD_DRAIN_CYCLES(4), .MAX_WR_RUN(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_overflow(wr_overflow),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_end_burst(rd_end_burst),
        .rd_ack(rd_ack), .rd_data_available(rd_data_available),
        .p0_addr(p0_addr), .p0_data(p0_data),
        .p0_wr_req(p0_wr_req), .p0_rd_req(p0_rd_req),
        .p0_end_burst_req(p0_end_burst_req),
        .p0_data_available(p0_data_available), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [24:0] addr,
                             input logic [15:0] data, input int gap);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic set_wr(input logic [24:0] addr, input logic [15:0] data);
        wr_req = 1'b1; wr_addr = addr; wr_data = data;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; rd_end_burst = 1'b0; p0_data_available = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        check({name, "_idle"}, 64'(busy), 64'd0);
        check({name, "_events_seen"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_ack(input string name, input int max_cycles);
        logic found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (rd_ack) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_rd_ack_seen"}, 64'(found), 64'd1);
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({p0_addr, p0_data, p0_wr_req, p0_rd_req, p0_end_burst_req,
                    rd_ack, rd_data_available, busy, wr_overflow, wr_ready});
    endfunction

    // Monitor: every port-0 strobe must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        ev_t         e;
        logic [1:0]  k;
        logic [63:0] act, expv;
        if (reset_n && (p0_wr_req || p0_rd_req || rd_ack || p0_end_burst_req)) begin
            check("strobe_exclusive", 64'(p0_wr_req && p0_rd_req), 64'd0);
            k = p0_wr_req ? K_WR : ((p0_rd_req || rd_ack) ? K_RD : K_EB);
            if (k == K_RD) check("rd_ack_with_rd_req", 64'({rd_ack, p0_rd_req}), 64'd3);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 64'(k), 64'd0);
            end else begin
                e    = exp_q.pop_front();
                act  = 64'({k, (k != K_EB) ? p0_addr : 25'd0, (k == K_WR) ? p0_data : 16'd0});
                expv = 64'({e.kind, (e.kind != K_EB) ? e.addr : 25'd0,
                            (e.kind == K_WR) ? e.data : 16'd0});
                check("event", act, expv);
                if (e.gap >= 0) check("event_gap", 64'(cyc - last_cyc), 64'(e.gap));
            end
            last_cyc = cyc;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state and back-to-back writes.
        do_reset();
        check("reset_outputs", out_vec(), 64'd1);
        expect_ev(K_WR, 25'h10, 16'hA1, -1);
        expect_ev(K_WR, 25'h11, 16'hA2, 9);
        expect_ev(K_WR, 25'h12, 16'hA3, 9);
        set_wr(25'h10, 16'hA1); tick();
        set_wr(25'h11, 16'hA2); tick();
        set_wr(25'h12, 16'hA3); tick();
        wr_req = 1'b0;
        check("t1_write_hold", 64'({p0_wr_req, p0_addr, p0_data}), 64'({1'b0, 25'h10, 16'hA1}));
        wait_idle("t1", 60);
        check("t1_no_overflow", 64'(wr_overflow), 64'd0);

        // Overflow: six back-to-back writes into a depth-4 FIFO.
        do_reset();
        for (int i = 0; i < 5; i++) expect_ev(K_WR, 25'h20 + 25'(i), 16'hB0 + 16'(i), (i == 0) ? -1 : 9);
        for (int i = 0; i < 6; i++) begin
            set_wr(25'h20 + 25'(i), 16'hB0 + 16'(i));
            if (i == 5) check("t2_wr_ready_full", 64'(wr_ready), 64'd0);
            tick();
        end
        wr_req = 1'b0;
        check("t2_overflow_set", 64'(wr_overflow), 64'd1);
        wait_idle("t2", 100);
        check("t2_overflow_sticky", 64'(wr_overflow), 64'd1);

        // Read during writes with MAX_WR_RUN = 2.
        do_reset();
        expect_ev(K_WR, 25'h60, 16'hC0, -1);
        expect_ev(K_WR, 25'h61, 16'hC1, 9);
        expect_ev(K_RD, 25'h100, 16'h0, 9);
        expect_ev(K_EB, 25'h0, 16'h0, 3);
        expect_ev(K_WR, 25'h62, 16'hC2, 5);
        expect_ev(K_WR, 25'h63, 16'hC3, 9);
        expect_ev(K_WR, 25'h64, 16'hC4, 9);
        set_wr(25'h60, 16'hC0);
        rd_req = 1'b1; rd_addr = 25'h100;
        tick();
        rd_req = 1'b0;
        for (int i = 1; i < 5; i++) begin
            set_wr(25'h60 + 25'(i), 16'hC0 + 16'(i));
            tick();
        end
        wr_req = 1'b0;
        check("t3_fifo_full", 64'(wr_ready), 64'd0);
        wait_ack("t3", 40);
        tick();
        p0_data_available = 1'b1;
        #1 check("t3_rd_data_passthrough", 64'(rd_data_available), 64'd1);
        p0_data_available = 1'b0;
        tick();
        tick();
        rd_end_burst = 1'b1;
        tick();
        rd_end_burst = 1'b0;
        wait_idle("t3", 100);
        check("t3_no_overflow", 64'(wr_overflow), 64'd0);

        // Burst isolation: writes and data-valid pulses around a burst.
        do_reset();
        expect_ev(K_RD, 25'h300, 16'h0, -1);
        expect_ev(K_EB, 25'h0, 16'h0, 3);
        expect_ev(K_WR, 25'h40, 16'hD0, 5);
        expect_ev(K_WR, 25'h41, 16'hD1, 9);
        p0_data_available = 1'b1;
        #1 check("t4_idle_gating", 64'(rd_data_available), 64'd0);
        p0_data_available = 1'b0;
        rd_req = 1'b1; rd_addr = 25'h300;
        tick();
        rd_req = 1'b0;
        wait_ack("t4", 10);
        tick();
        set_wr(25'h40, 16'hD0);
        p0_data_available = 1'b1;
        #1 check("t4_read_passthrough", 64'(rd_data_available), 64'd1);
        p0_data_available = 1'b0;
        tick();
        set_wr(25'h41, 16'hD1);
        tick();
        wr_req = 1'b0;
        rd_end_burst = 1'b1;
        tick();
        rd_end_burst = 1'b0;
        tick();
        p0_data_available = 1'b1;
        #1 check("t4_drain_gating", 64'({rd_data_available, p0_wr_req}), 64'd0);
        p0_data_available = 1'b0;
        wait_idle("t4", 60);

        // Duplicate read request while the first is pending and during the burst.
        do_reset();
        expect_ev(K_WR, 25'h50, 16'hE0, -1);
        expect_ev(K_RD, 25'h180, 16'h0, 9);
        expect_ev(K_EB, 25'h0, 16'h0, 2);
        set_wr(25'h50, 16'hE0);
        rd_req = 1'b1; rd_addr = 25'h180;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
        tick();
        rd_req = 1'b1; rd_addr = 25'h200;
        tick();
        rd_req = 1'b0;
        wait_ack("t5", 20);
        tick();
        rd_req = 1'b1; rd_addr = 25'h200;
        tick();
        rd_req = 1'b0;
        rd_end_burst = 1'b1;
        tick();
        rd_end_burst = 1'b0;
        wait_idle("t5", 30);
        repeat (20) tick();
        check("t5_single_burst", 64'({busy, 32'(exp_q.size())}), 64'd0);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        expect_ev(K_RD, 25'h3AA, 16'h0, -1);
        rd_req = 1'b1; rd_addr = 25'h3AA;
        tick();
        rd_req = 1'b0;
        wait_ack("t6", 10);
        tick();
        set_wr(25'h70, 16'hF0);
        tick();
        wr_req = 1'b0;
        check("t6_busy_before_reset", 64'(busy), 64'd1);
        p0_data_available = 1'b1;
        rd_end_burst = 1'b1;
        #2 reset_n = 1'b0;
        #1 check("t6_reset_outputs", out_vec(), 64'd1);
        p0_data_available = 1'b0;
        rd_end_burst = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("t6_idle_after_release", 64'({busy, wr_ready}), 64'd1);
        repeat (15) tick();
        check("t6_no_stale_events", 64'({p0_wr_req, p0_rd_req, 32'(exp_q.size())}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
